// File: rtl/uart_tx_tick.sv
// Byte-wide UART transmitter paced by an external OVERSAMPLE x baud tick.
// Small input FIFO, tick-aligned framing, optional parity and a second stop bit.
module uart_tx_tick #(
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int W_LEVEL    = $clog2(FIFO_DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               baud_tick,
    input  logic               parity_en,
    input  logic               parity_odd,
    input  logic               two_stop,
    input  logic [7:0]         din,
    input  logic               din_valid,
    output logic               din_ready,
    output logic               tx,
    output logic               busy,
    output logic [W_LEVEL-1:0] fifo_level
);

    localparam int W_PTR = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int W_TCK = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [W_TCK-1:0]   TCK_LAST = W_TCK'(OVERSAMPLE - 1);
    localparam logic [W_LEVEL-1:0] LVL_FULL = W_LEVEL'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    // ------------------------------------------------------------------
    // Input FIFO
    // ------------------------------------------------------------------
    logic [7:0]         mem [FIFO_DEPTH];
    logic [W_PTR-1:0]   wr_ptr;
    logic [W_PTR-1:0]   rd_ptr;
    logic [W_LEVEL-1:0] level;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;

    assign fifo_full  = (level == LVL_FULL);
    assign fifo_empty = (level == '0);
    // rst_n gate keeps ready low while reset is held, independent of en
    assign din_ready  = rst_n & en & ~fifo_full;
    assign push       = din_valid & din_ready;
    assign fifo_level = level;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (!en) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Framing FSM
    // ------------------------------------------------------------------
    state_t           state, state_nx;
    logic [W_TCK-1:0] tick_cnt, tick_nx;
    logic [2:0]       bit_idx, bit_nx;
    logic             stop_half, stop_half_nx;
    logic [7:0]       data_q, data_nx;
    logic             cfg_par, cfg_par_nx;
    logic             cfg_odd, cfg_odd_nx;
    logic             cfg_two, cfg_two_nx;
    logic             tx_nx;
    logic             bit_end;

    assign bit_end = baud_tick & (tick_cnt == TCK_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            bit_idx   <= '0;
            stop_half <= 1'b0;
            data_q    <= '0;
            cfg_par   <= 1'b0;
            cfg_odd   <= 1'b0;
            cfg_two   <= 1'b0;
            tx        <= 1'b1;
        end else begin
            state     <= state_nx;
            tick_cnt  <= tick_nx;
            bit_idx   <= bit_nx;
            stop_half <= stop_half_nx;
            data_q    <= data_nx;
            cfg_par   <= cfg_par_nx;
            cfg_odd   <= cfg_odd_nx;
            cfg_two   <= cfg_two_nx;
            tx        <= tx_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        tick_nx      = tick_cnt;
        bit_nx       = bit_idx;
        stop_half_nx = stop_half;
        data_nx      = data_q;
        cfg_par_nx   = cfg_par;
        cfg_odd_nx   = cfg_odd;
        cfg_two_nx   = cfg_two;
        pop          = 1'b0;

        if (!en) begin
            state_nx     = IDLE;
            tick_nx      = '0;
            bit_nx       = '0;
            stop_half_nx = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Start only on a tick so every bit spans exactly OVERSAMPLE ticks
                    if (baud_tick && !fifo_empty) begin
                        state_nx     = START;
                        pop          = 1'b1;
                        data_nx      = mem[rd_ptr];
                        cfg_par_nx   = parity_en;
                        cfg_odd_nx   = parity_odd;
                        cfg_two_nx   = two_stop;
                        tick_nx      = '0;
                        bit_nx       = '0;
                        stop_half_nx = 1'b0;
                    end
                end
                default: begin
                    if (baud_tick)
                        tick_nx = bit_end ? '0 : tick_cnt + 1'b1;
                    if (bit_end) begin
                        case (state)
                            START: begin
                                state_nx = DATA;
                                bit_nx   = '0;
                            end
                            DATA: begin
                                if (bit_idx == 3'd7) begin
                                    state_nx     = cfg_par ? PARITY : STOP;
                                    stop_half_nx = 1'b0;
                                end else begin
                                    bit_nx = bit_idx + 3'd1;
                                end
                            end
                            PARITY: begin
                                state_nx     = STOP;
                                stop_half_nx = 1'b0;
                            end
                            STOP: begin
                                if (cfg_two && !stop_half) begin
                                    stop_half_nx = 1'b1;
                                end else if (!fifo_empty) begin
                                    // Back-to-back: next start bit follows with no gap
                                    state_nx     = START;
                                    pop          = 1'b1;
                                    data_nx      = mem[rd_ptr];
                                    bit_nx       = '0;
                                    stop_half_nx = 1'b0;
                                end else begin
                                    state_nx     = IDLE;
                                    stop_half_nx = 1'b0;
                                end
                            end
                            default: state_nx = IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

    // Line value for the next cycle, registered into tx
    always_comb begin
        tx_nx = 1'b1;
        case (state_nx)
            START:   tx_nx = 1'b0;
            DATA:    tx_nx = data_nx[bit_nx];
            PARITY:  tx_nx = (^data_nx) ^ cfg_odd_nx;
            default: tx_nx = 1'b1;
        endcase
    end

    assign busy = (state != IDLE) | (level != '0);

endmodule

// File: tb/tb_uart_tx_tick.sv
// Scoreboard bench for uart_tx_tick: pushed bytes are queued as expected frames,
// a line receiver decodes tx and compares each frame against the queue head.
module tb_uart_tx_tick;

    localparam int OS    = 4;
    localparam int DEPTH = 4;
    localparam int WL    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          baud_tick = 1'b0;
    logic          parity_en = 1'b0;
    logic          parity_odd = 1'b0;
    logic          two_stop = 1'b0;
    logic [7:0]    din = 8'h00;
    logic          din_valid = 1'b0;
    logic          din_ready;
    logic          tx;
    logic          busy;
    logic [WL-1:0] fifo_level;

    typedef struct {
        logic [7:0] data;
        logic       par_en;
        logic       par_odd;
        logic       two;
    } frame_t;

    frame_t sb[$];
    int     starts[$];
    int     ends[$];
    int     n_chk = 0;
    int     n_err = 0;
    int     tick_period = 1;
    logic   tick_gate = 1'b0;
    int     cyc = 0;
    logic   tick_q = 1'b0;
    logic   rx_busy = 1'b0;

    uart_tx_tick #(.OVERSAMPLE(OS), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .baud_tick  (baud_tick),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .two_stop   (two_stop),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .tx         (tx),
        .busy       (busy),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        tick_q <= baud_tick;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Tick source: one pulse every tick_period cycles while gated on
    initial begin : tick_gen
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (tick_gate) begin
                baud_tick = (cnt == 0);
                cnt = (cnt + 1 >= tick_period) ? 0 : cnt + 1;
            end else begin
                baud_tick = 1'b0;
                cnt = 0;
            end
        end
    end

    // Line receiver: counts ticks per bit, checks stability and bit length
    initial begin : rx
        frame_t      e;
        logic [11:0] bits;
        int          nb, tk, c, cmin, cmax, start_c;
        logic        val, glitch, abort, aligned;
        forever begin
            @(negedge clk);
            if (en && rst_n && tx === 1'b0) begin
                rx_busy = 1'b1;
                start_c = cyc;
                aligned = tick_q;
                chk("frame_expected", (sb.size() != 0), 1);
                if (sb.size() != 0) e = sb[0];
                else begin
                    e.data = 8'h00; e.par_en = 1'b0; e.par_odd = 1'b0; e.two = 1'b0;
                end
                nb = 10 + int'(e.par_en) + int'(e.two);
                bits = '0; abort = 1'b0; glitch = 1'b0; cmin = 100000; cmax = 0;
                for (int b = 0; b < nb && !abort; b++) begin
                    val = tx; c = 0; tk = 0;
                    while (tk < OS && !abort) begin
                        if (!en) abort = 1'b1;
                        else begin
                            if (tx !== val) glitch = 1'b1;
                            c++;
                            if (baud_tick) tk++;
                            if (tk < OS) @(negedge clk);
                        end
                    end
                    bits[b] = val;
                    if (c < cmin) cmin = c;
                    if (c > cmax) cmax = c;
                    if (!abort && b == nb - 1) ends.push_back(cyc);
                    if (!abort && b < nb - 1) @(negedge clk);
                end
                if (!abort) begin
                    if (sb.size() != 0) void'(sb.pop_front());
                    starts.push_back(start_c);
                    chk("start_bit", bits[0], 0);
                    chk("data", bits[8:1], e.data);
                    if (e.par_en) chk("parity", bits[9], (^e.data) ^ e.par_odd);
                    chk("stop_bit", bits[nb-1], 1);
                    if (e.two) chk("stop_bit2", bits[nb-2], 1);
                    chk("bit_len_min", cmin, OS * tick_period);
                    chk("bit_len_max", cmax, OS * tick_period);
                    chk("bit_stable", glitch, 0);
                    chk("tick_aligned", aligned, 1);
                end
                rx_busy = 1'b0;
            end
        end
    end

    task automatic push_byte(input logic [7:0] d);
        int     w;
        frame_t f;
        w = 0;
        din = d; din_valid = 1'b1;
        @(negedge clk);
        while (!din_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("push_ready", din_ready, 1);
        if (din_ready) begin
            f.data = d; f.par_en = parity_en; f.par_odd = parity_odd; f.two = two_stop;
            sb.push_back(f);
        end
        @(posedge clk); #1;
        din_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, output int done_cyc);
        int   w;
        logic done;
        w = 0; done = 1'b0; done_cyc = 0;
        while (!done && w < 2000) begin
            @(negedge clk);
            w++;
            done = (sb.size() == 0) && !busy && !rx_busy;
        end
        done_cyc = cyc;
        chk(tag, done, 1);
        @(posedge clk); #1;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int dc;
        frame_t f;
        // Reset state with valid asserted during reset
        en = 1'b1; din_valid = 1'b1; din = 8'h55;
        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_ready", din_ready, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk); #1;
        din_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("post_rst_ready", din_ready, 1);
        chk("post_rst_level", fifo_level, 0);
        @(posedge clk); #1;

        // Basic frame, ticks every cycle
        tick_period = 1; tick_gate = 1'b1;
        push_byte(8'hA5);
        wait_idle("t2_idle", dc);
        chk("t2_busy_fall", dc, ends[$] + 1);

        // Parity even/odd, then two stop bits
        parity_en = 1'b1; parity_odd = 1'b0;
        push_byte(8'hA5);
        wait_idle("t3_even_idle", dc);
        parity_odd = 1'b1;
        push_byte(8'hA5);
        wait_idle("t3_odd_idle", dc);
        parity_en = 1'b0; two_stop = 1'b1;
        push_byte(8'h3C);
        wait_idle("t3_two_idle", dc);
        parity_en = 1'b1; parity_odd = 1'b0;
        push_byte(8'h01);
        wait_idle("t3_par_two_idle", dc);
        parity_en = 1'b0; two_stop = 1'b0;

        // Fill the FIFO with ticks gated off, then drain back-to-back
        tick_gate = 1'b0;
        repeat (2) @(posedge clk); #1;
        starts.delete(); ends.delete();
        for (int i = 0; i < 6; i++) begin
            din = 8'h10 + 8'(i * 17); din_valid = 1'b1;
            @(negedge clk);
            chk("t4_level", fifo_level, (i < DEPTH) ? i : DEPTH);
            if (i < DEPTH) begin
                chk("t4_ready", din_ready, 1);
                f.data = din; f.par_en = 1'b0; f.par_odd = 1'b0; f.two = 1'b0;
                sb.push_back(f);
            end else begin
                chk("t4_full_ready", din_ready, 0);
            end
            @(posedge clk); #1;
        end
        din_valid = 1'b0;
        tick_gate = 1'b1;
        begin
            int w;
            w = 0;
            @(negedge clk);
            while (fifo_level == WL'(DEPTH) && w < 20) begin
                @(negedge clk);
                w++;
            end
            chk("t4_pop_level", fifo_level, DEPTH - 1);
            chk("t4_ready_again", din_ready, 1);
        end
        wait_idle("t4_idle", dc);
        chk("t4_frames", starts.size(), DEPTH);
        for (int i = 1; i < starts.size() && i < ends.size() + 1; i++)
            chk("t4_gap", starts[i] - ends[i-1] - 1, 0);

        // Slow ticks: every third cycle
        tick_period = 3;
        push_byte(8'h96);
        push_byte(8'h0F);
        wait_idle("t5_idle", dc);
        tick_period = 1;

        // Abort mid-DATA with bytes queued
        tick_gate = 1'b0;
        repeat (2) @(posedge clk); #1;
        push_byte(8'h81);
        push_byte(8'h42);
        push_byte(8'h24);
        chk("t6_level_full3", fifo_level, 3);
        tick_gate = 1'b1;
        repeat (9) @(negedge clk);
        chk("t6_pre_level", fifo_level, 2);
        chk("t6_pre_busy", busy, 1);
        @(posedge clk); #1;
        en = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("t6_abort_tx", tx, 1);
        chk("t6_abort_level", fifo_level, 0);
        chk("t6_abort_busy", busy, 0);
        chk("t6_abort_ready", din_ready, 0);
        sb.delete();
        repeat (3) @(negedge clk);
        chk("t6_hold_tx", tx, 1);
        @(posedge clk); #1;
        en = 1'b1;
        starts.delete(); ends.delete();
        push_byte(8'h00);
        wait_idle("t6_idle", dc);
        chk("t6_frames", starts.size(), 1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
